// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bundle between a master and the axil_slave_regfile responder.
interface axil_slave_regfile_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite register file: NUM_REGS-1 RW control words plus one RO status word.
// Define AXIL_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_slave_regfile #(
  parameter int          ADDR_W   = 8,
  parameter int          NUM_REGS = 4,
  parameter logic [31:0] RST_VAL  = '0
) (
  input  logic                   aclk,
  input  logic                   areset,
  axil_slave_regfile_if.slave    s_axi,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]    wr_pulse,
  input  logic [31:0]            status_in
);
  localparam int         IDX_W       = ADDR_W - 2;
  localparam int         NUM_RW      = NUM_REGS - 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e            w_state_q, w_state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                aw_got_q, aw_got_d;
  logic                w_got_q, w_got_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [31:0]         regs_q [NUM_RW];
  logic [31:0]         regs_d [NUM_RW];

  r_state_e            r_state_q, r_state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic [IDX_W-1:0]    ridx;
  logic [31:0]         rd_word;
  logic [1:0]          rd_resp;
  logic [1:0]          wr_resp;
  logic                unused_addr_lsbs;

  // Byte lanes inside a word are selected by wstrb, so the address LSBs carry no information.
  assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};
  assign ridx             = s_axi.araddr[ADDR_W-1:2];

`ifdef AXIL_SLAVE_SLVERR_EN
  assign wr_resp = (int'(widx_q) >= NUM_REGS) ? RESP_SLVERR : RESP_OKAY;
  assign rd_resp = (int'(ridx) >= NUM_REGS) ? RESP_SLVERR : RESP_OKAY;
`else
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_d  = w_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_got_d   = aw_got_q;
    w_got_d    = w_got_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && awready_q) begin
          aw_got_d = 1'b1;
          widx_d   = s_axi.awaddr[ADDR_W-1:2];
        end
        if (s_axi.wvalid && wready_q) begin
          w_got_d = 1'b1;
          wdata_d = s_axi.wdata;
          wstrb_d = s_axi.wstrb;
        end
        awready_d = !aw_got_d;
        wready_d  = !w_got_d;
        if (aw_got_q && w_got_q) begin
          // Only RW slots match here: the RO word and out-of-range indices fall through.
          for (int k = 0; k < NUM_RW; k++) begin
            if (widx_q == IDX_W'(k)) begin
              for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
              end
              wr_pulse_d[k] = 1'b1;
            end
          end
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = wr_resp;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      widx_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      // NOTE: these are control registers seen by fabric, so unlike a RAM they must reset.
      for (int k = 0; k < NUM_RW; k++) regs_q[k] <= RST_VAL;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      if (ridx == IDX_W'(k)) rd_word = regs_q[k];
    end
    if (ridx == IDX_W'(NUM_RW)) rd_word = status_in;
  end

  // Read captures from regs_q, so a write committing on the same edge is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi.arvalid && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rresp_d   = rd_resp;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_RW; k++) reg_out[32*k +: 32] = regs_q[k];
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
endmodule

// File: tb/tb_axil_slave_regfile.sv
// Scoreboard bench for axil_slave_regfile: stimulus pushes expected B/R responses,
// monitors pop and compare when the DUT presents them.
module tb_axil_slave_regfile;
  localparam int          ADDR_W   = 8;
  localparam int          NUM_REGS = 4;
  localparam int          LIMIT    = 40;
  localparam logic [31:0] RST_VAL  = 32'h0F0F_A5A5;
  localparam logic [1:0]  OKAY     = 2'b00;
`ifdef AXIL_SLAVE_SLVERR_EN
  localparam logic [1:0]  OOR_RESP = 2'b10;
`else
  localparam logic [1:0]  OOR_RESP = 2'b00;
`endif

  typedef struct {
    logic [1:0]            resp;
    logic [NUM_REGS-1:0]   pulse;
    logic [NUM_REGS*32-1:0] regs;
  } b_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic                   aclk = 1'b0;
  logic                   areset;
  logic [NUM_REGS*32-1:0] reg_out;
  logic [NUM_REGS-1:0]    wr_pulse;
  logic [31:0]            status_in;

  axil_slave_regfile_if #(.ADDR_W(ADDR_W)) s_axi ();

  axil_slave_regfile #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .RST_VAL  (RST_VAL)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .s_axi     (s_axi),
    .reg_out   (reg_out),
    .wr_pulse  (wr_pulse),
    .status_in (status_in)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain word array; the RO slot is never stored.
  logic [31:0] model [NUM_REGS];
  b_exp_t      b_q [$];
  r_exp_t      r_q [$];
  int          last_hs = 0;

  function automatic logic [NUM_REGS*32-1:0] model_pack();
    logic [NUM_REGS*32-1:0] v = '0;
    for (int k = 0; k < NUM_REGS - 1; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NUM_REGS; k++) model[k] = RST_VAL;
  endfunction

  task automatic expect_write(input logic [7:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output b_exp_t e);
    int idx = int'(addr) / 4;
    e.resp  = OKAY;
    e.pulse = '0;
    if (idx < NUM_REGS - 1) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      e.pulse[idx] = 1'b1;
    end else if (idx >= NUM_REGS) begin
      e.resp = OOR_RESP;
    end
    e.regs = model_pack();
    b_q.push_back(e);
  endtask

  task automatic expect_read(input logic [7:0] addr);
    r_exp_t e;
    int idx = int'(addr) / 4;
    e.resp = OKAY;
    e.data = '0;
    if (idx < NUM_REGS - 1)       e.data = model[idx];
    else if (idx == NUM_REGS - 1) e.data = status_in;
    else                          e.resp = OOR_RESP;
    r_q.push_back(e);
  endtask

  // Write-response monitor: compares on the first cycle bvalid is presented.
  b_exp_t be;
  logic   bvalid_prev = 1'b0;
  always @(negedge aclk) begin
    if (s_axi.bvalid && !bvalid_prev) begin
      if (b_q.size() == 0) begin
        check("b_unexpected", 1, 0);
      end else begin
        be = b_q.pop_front();
        check("bresp", s_axi.bresp, be.resp);
        check("wr_pulse", wr_pulse, be.pulse);
        check("reg_out", reg_out, be.regs);
        check("b_latency", cyc, last_hs + 1);
      end
    end else begin
      check("wr_pulse_quiet", wr_pulse, 0);
    end
    bvalid_prev = s_axi.bvalid;
  end

  r_exp_t re;
  always @(negedge aclk) begin
    if (s_axi.rvalid && s_axi.rready) begin
      if (r_q.size() == 0) begin
        check("r_unexpected", 1, 0);
      end else begin
        re = r_q.pop_front();
        check("rdata", s_axi.rdata, re.data);
        check("rresp", s_axi.rresp, re.resp);
      end
    end
  end

  task automatic apply_reset();
    areset = 1'b1;
    model_reset();
    #1;
    check("rst_awready", s_axi.awready, 0);
    check("rst_wready", s_axi.wready, 0);
    check("rst_arready", s_axi.arready, 0);
    check("rst_bvalid", s_axi.bvalid, 0);
    check("rst_rvalid", s_axi.rvalid, 0);
    check("rst_bresp", s_axi.bresp, 0);
    check("rst_rresp", s_axi.rresp, 0);
    check("rst_rdata", s_axi.rdata, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_reg_out", reg_out, model_pack());
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("rel_readies_low", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
    @(posedge aclk);
    #1;
    check("rel_readies_up", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input bit stray);
    b_exp_t e;
    int     n;
    expect_write(addr, data, strb, e);
    last_hs = 0;
    fork
      begin
        int m = 0;
        repeat (aw_dly) @(posedge aclk);
        if (aw_dly > 0) #1;
        s_axi.awaddr  = addr;
        s_axi.awvalid = 1'b1;
        do begin @(negedge aclk); m++; end while (!s_axi.awready && m < LIMIT);
        if (!s_axi.awready) check("aw_timeout", 0, 1);
        else if (cyc + 1 > last_hs) last_hs = cyc + 1;
        @(posedge aclk);
        #1 s_axi.awvalid = 1'b0;
      end
      begin
        int m = 0;
        repeat (w_dly) @(posedge aclk);
        if (w_dly > 0) #1;
        s_axi.wdata  = data;
        s_axi.wstrb  = strb;
        s_axi.wvalid = 1'b1;
        do begin @(negedge aclk); m++; end while (!s_axi.wready && m < LIMIT);
        if (!s_axi.wready) check("w_timeout", 0, 1);
        else if (cyc + 1 > last_hs) last_hs = cyc + 1;
        @(posedge aclk);
        #1 s_axi.wvalid = 1'b0;
      end
    join
    n = 0;
    while (!s_axi.bvalid && n < LIMIT) begin @(negedge aclk); n++; end
    if (!s_axi.bvalid) check("b_timeout", 0, 1);
    for (int i = 0; i < b_dly; i++) begin
      @(posedge aclk);
      #1;
      if (stray) begin
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
      end
      @(negedge aclk);
      check("bvalid_held", s_axi.bvalid, 1);
      check("bresp_held", s_axi.bresp, e.resp);
      check("no_aw_in_resp", s_axi.awready, 0);
      check("no_w_in_resp", s_axi.wready, 0);
    end
    @(posedge aclk);
    #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    s_axi.bready  = 1'b1;
    @(posedge aclk);
    #1;
    s_axi.bready = 1'b0;
    check("w_readies_back", {s_axi.bvalid, s_axi.awready, s_axi.wready}, 3'b011);
  endtask

  task automatic axi_read(input logic [7:0] addr, input int ar_dly, input int r_dly);
    int n = 0;
    expect_read(addr);
    repeat (ar_dly) @(posedge aclk);
    if (ar_dly > 0) #1;
    s_axi.araddr  = addr;
    s_axi.arvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!s_axi.arready && n < LIMIT);
    if (!s_axi.arready) check("ar_timeout", 0, 1);
    @(posedge aclk);
    #1 s_axi.arvalid = 1'b0;
    check("rvalid_latency", s_axi.rvalid, 1);
    check("arready_low", s_axi.arready, 0);
    repeat (r_dly) begin
      @(negedge aclk);
      check("rvalid_held", s_axi.rvalid, 1);
    end
    @(posedge aclk);
    #1 s_axi.rready = 1'b1;
    @(posedge aclk);
    #1 s_axi.rready = 1'b0;
    check("arready_back", {s_axi.rvalid, s_axi.arready}, 2'b01);
  endtask

  // Leaves a write response pending, then pulses areset under it.
  task automatic reset_mid_write();
    b_exp_t e;
    expect_write(8'h08, 32'h0BAD_F00D, 4'hF, e);
    s_axi.awaddr  = 8'h08;
    s_axi.wdata   = 32'h0BAD_F00D;
    s_axi.wstrb   = 4'hF;
    s_axi.awvalid = 1'b1;
    s_axi.wvalid  = 1'b1;
    @(negedge aclk);
    check("mid_aw_w_ready", {s_axi.awready, s_axi.wready}, 2'b11);
    last_hs = cyc + 1;
    @(posedge aclk);
    #1;
    s_axi.awvalid = 1'b0;
    s_axi.wvalid  = 1'b0;
    @(posedge aclk);
    #1 check("mid_bvalid_pending", s_axi.bvalid, 1);
    @(negedge aclk);
    #2 apply_reset();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    areset        = 1'b1;
    status_in     = 32'hCAFE_0001;
    s_axi.awaddr  = '0;
    s_axi.awvalid = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.wvalid  = 1'b0;
    s_axi.bready  = 1'b0;
    s_axi.araddr  = '0;
    s_axi.arvalid = 1'b0;
    s_axi.rready  = 1'b0;
    apply_reset();

    axi_write(8'h00, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0);
    axi_write(8'h04, 32'h5555_6666, 4'hF, 3, 0, 4, 1'b1);
    axi_read(8'h04, 0, 0);

    axi_write(8'h04, 32'h1122_3344, 4'hF, 0, 1, 0, 1'b0);
    axi_write(8'h04, 32'hAABB_CCDD, 4'b0101, 1, 0, 0, 1'b0);
    axi_read(8'h04, 0, 2);

    axi_read(8'h0C, 0, 0);
    axi_write(8'h0C, 32'h1234_5678, 4'hF, 0, 0, 0, 1'b0);
    axi_read(8'h0C, 1, 0);

    axi_write(8'h08, 32'hFFFF_FFFF, 4'h0, 0, 0, 1, 1'b0);
    axi_write(8'h0B, 32'h7788_99AA, 4'b1000, 2, 2, 0, 1'b0);
    axi_read(8'h09, 0, 0);

    axi_write(8'h40, 32'h0123_4567, 4'hF, 0, 0, 0, 1'b0);
    axi_read(8'h40, 0, 0);

    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end else begin
        status_in = $urandom;
        axi_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    reset_mid_write();
    axi_read(8'h00, 0, 0);
    axi_read(8'h08, 0, 0);

    check("b_queue_empty", b_q.size(), 0);
    check("r_queue_empty", r_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
